// File: rtl/data_demux_2to1.sv
// data_demux_2to1: buffered 1-to-2 demux steering valid/ready words into two FWFT FIFOs.
module data_demux_2to1 #(
    parameter int size  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [size-1:0]  data_i,
    input  logic             select_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [size-1:0]  data0_o,
    output logic             valid0_o,
    input  logic             ready0_i,
    output logic [size-1:0]  data1_o,
    output logic             valid1_o,
    input  logic             ready1_i,
    output logic [CNT_W-1:0] sent0_o,
    output logic [CNT_W-1:0] sent1_o,
    output logic             busy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    logic [size-1:0]  mem    [2][DEPTH];
    logic [AW-1:0]    wr_ptr [2];
    logic [AW-1:0]    rd_ptr [2];
    logic [AW:0]      count  [2];
    logic [CNT_W-1:0] sent   [2];
    logic [1:0]       full, push, pop;
    assign full     = {count[1] == FULL_CNT, count[0] == FULL_CNT};
    // full FIFOs refuse pushes regardless of a same-cycle pop, keeping readyk_i off this path
    assign ready_o  = select_i ? !full[1] : !full[0];
    assign push     = {2{valid_i && ready_o}} & {select_i, !select_i};
    assign valid0_o = count[0] != '0;
    assign valid1_o = count[1] != '0;
    assign pop      = {valid1_o && ready1_i, valid0_o && ready0_i};
    assign data0_o  = mem[0][rd_ptr[0]];
    assign data1_o  = mem[1][rd_ptr[1]];
    assign sent0_o  = sent[0];
    assign sent1_o  = sent[1];
    assign busy_o   = valid0_o | valid1_o;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
                sent[k]   <= '0;
                for (int i = 0; i < DEPTH; i++) mem[k][i] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push[k]) begin
                    mem[k][wr_ptr[k]] <= data_i;
                    wr_ptr[k]         <= wr_ptr[k] + 1'b1;
                end
                if (pop[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + 1'b1;
                    sent[k]   <= sent[k] + 1'b1;
                end
                count[k] <= count[k] + {{AW{1'b0}}, push[k]} - {{AW{1'b0}}, pop[k]};
            end
        end
    end
endmodule
